// File: rtl/pe_psum_injector.sv
// Network-interface stage packing up to three 8-bit partial sums into one
// 35-bit NoC packet with a dst/src/type/lane-count header.
module pe_psum_injector #(
    parameter int unsigned              WIDTH      = 35,
    parameter int unsigned              WIDTH_ADDR = 3,
    parameter logic [WIDTH_ADDR-1:0]    SRC_ADDR   = 3'b001,
    parameter logic [WIDTH_ADDR-1:0]    DST_ADDR   = 3'b000,
    parameter int unsigned              LANES      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      pkt_count,
    output logic             busy
);

    localparam int unsigned LANE_W    = 2;
    localparam int unsigned PAYLOAD_W = 24;
    localparam int unsigned CNT_W     = 16;

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [1:0] TYPE_MORE = 2'b00;
    localparam logic [1:0] TYPE_LAST = 2'b01;

    logic [0:0]           r_state;
    logic [LANE_W-1:0]    r_lane;
    logic [PAYLOAD_W-1:0] r_payload;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_in_ready;
    logic [CNT_W-1:0]     r_pkt_count;
    logic                 r_busy;

    logic [0:0]           w_state_nxt;
    logic [LANE_W-1:0]    w_lane_nxt;
    logic [PAYLOAD_W-1:0] w_payload_nxt;
    logic [PAYLOAD_W-1:0] w_payload_ins;
    logic                 w_out_valid_nxt;
    logic [WIDTH-1:0]     w_out_data_nxt;
    logic                 w_in_ready_nxt;
    logic [CNT_W-1:0]     w_pkt_count_nxt;
    logic                 w_busy_nxt;
    logic                 w_accept;
    logic                 w_close;

    assign w_accept = in_valid && r_in_ready;
    assign w_close  = (r_lane == LANE_W'(LANES - 1)) || in_last;

    // Payload with the incoming beat merged into the current lane slot
    always_comb begin
        w_payload_ins = r_payload;
        case (r_lane)
            2'd0:    w_payload_ins[7:0]   = in_data;
            2'd1:    w_payload_ins[15:8]  = in_data;
            2'd2:    w_payload_ins[23:16] = in_data;
            default: w_payload_ins        = r_payload;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_lane_nxt      = r_lane;
        w_payload_nxt   = r_payload;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_in_ready_nxt  = r_in_ready;
        w_pkt_count_nxt = r_pkt_count;

        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    w_payload_nxt = w_payload_ins;
                    if (w_close) begin
                        w_state_nxt     = S_SEND;
                        w_out_valid_nxt = 1'b1;
                        w_in_ready_nxt  = 1'b0;
                        w_out_data_nxt  = WIDTH'({DST_ADDR, SRC_ADDR,
                                                  (in_last ? TYPE_LAST : TYPE_MORE),
                                                  r_lane, 1'b0, w_payload_ins});
                    end else begin
                        w_lane_nxt = r_lane + 2'd1;
                    end
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    w_state_nxt     = S_FILL;
                    w_lane_nxt      = '0;
                    w_payload_nxt   = '0;
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_pkt_count_nxt = r_pkt_count + 16'd1;
                end
            end
            default: begin
                w_state_nxt     = S_FILL;
                w_lane_nxt      = '0;
                w_payload_nxt   = '0;
                w_out_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_SEND) || (w_lane_nxt != '0);
    end

    // State register; every register reloads from its next value each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_lane      <= '0;
            r_payload   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_pkt_count <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lane      <= w_lane_nxt;
            r_payload   <= w_payload_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_pkt_count <= w_pkt_count_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign pkt_count = r_pkt_count;
    assign busy      = r_busy;

endmodule
